stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
Parametrised BCD MM:SS stopwatch/timer core, next generation of the board's minute/second counter.
- Counts up (stopwatch) or down (countdown timer) on a 1 Hz tick; minute range set by parameter.
- Edge-detected pause/run toggle, adjust-mode digit loading with per-digit clamping, and an expiry/wrap pulse.
- Sits between the clock-divider/debouncer blocks and the 7-segment display driver.

Parameters:
MIN_MAX, 59, maximum minutes value (legal 1..99); count range 00:00..MIN_MAX:59
DIR_UP_DEFAULT, 1, direction after reset (1 up, 0 down)

Ports:
clk_c      in   1  system clock
reset_c    in   1  async active-high reset
tick_1hz   in   1  one-clk_c-cycle count-enable pulse
pause_c    in   1  debounced pause button level; rising edge toggles run
adj        in   1  adjust mode level
load_c     in   1  one-cycle strobe; writes NUM to digit SEL (adj=1 only)
sel        in   2  00 sec ones, 01 sec tens, 10 min ones, 11 min tens
num        in   4  value to load
dir_up     in   1  1 count up, 0 count down; sampled at each tick
clr_c      in   1  sync clear of all digits; run state unchanged
lap_c      in   1  lap button level (LAP_HOLD_EN only)
sec_ones   out  4  displayed BCD digit
sec_tens   out  4  displayed BCD digit
min_ones   out  4  displayed BCD digit
min_tens   out  4  displayed BCD digit
running    out  1  1 = counting enabled
wrap_p     out  1  one-cycle pulse on up-count wrap MIN_MAX:59 -> 00:00
done       out  1  sticky; countdown reached 00:00

Behaviour:
- Reset: reset_c async, active-high; clock clk_c.
  - On reset, all digits = 0, running = 0, wrap_p = 0, done = 0, pause edge register = 0, lap hold cleared.
  - Direction latch takes DIR_UP_DEFAULT until the first tick samples dir_up.
- Pause edge detect: pause_q registers pause_c; rise = pause_c & ~pause_q.
  - With adj=0, rise toggles running; the new value takes effect the next cycle.
  - A tick in the same cycle is governed by the pre-toggle running value.
- Pause-start clears done.
- Adjust mode (adj=1):
  - running is forced to 0 and held; pause edges are ignored.
  - Leaving adj leaves running = 0; a pause press is needed to start.
  - load_c writes num to the selected digit, clamped:
    - sec ones <= 9; sec tens <= 5.
    - min tens <= MIN_MAX/10.
    - min ones <= 9, or <= MIN_MAX%10 if min_tens == MIN_MAX/10.
  - After a min-tens load, min ones is re-clamped in the same cycle.
  - load_c clears done; load_c with adj=0 is ignored.
- Count (tick_1hz & running & ~adj & ~clr_c):
  - Up: sec ones +1, carry at 9 -> 0 into sec tens; sec tens carries at 5 -> 0 into minutes.
    - Minutes are a BCD increment to MIN_MAX.
    - At MIN_MAX:59 all digits -> 0 and wrap_p = 1 for exactly one cycle; running stays 1.
  - Down: mirror borrow chain; sec ones 0 -> 9, sec tens 0 -> 5.
    - On reaching 00:00, running = 0 and done = 1 in the same cycle.
    - A tick with running=1 at 00:00 (e.g. started at 00:00) sets done, clears running, keeps digits at 0.
- clr_c has priority over tick and load in the same cycle; it clears digits and done, not running.
- No digit ever leaves its legal range; all outputs are registered.
- Priority per cycle: reset_c > clr_c > adj/load > tick count.
- Latency: digit outputs change 1 clk_c after the qualifying tick/load.

Optional Feature:
Macro LAP_HOLD_EN.
- Defined: rising edge of lap_c (edge-detected like pause) while running toggles lap hold.
  - While held, output digits freeze at the captured value and internal counting continues.
  - A second edge releases the hold and outputs track live digits next cycle.
  - Lap hold is cleared by reset, clr_c, adj=1 and running falling.
- Not defined: lap_c ignored; outputs always equal live digits; no hold registers.

Test Plan:
1. Reset, pause rise, 65 ticks up -> 01:05, running=1, wrap_p never asserted.
2. adj=1, load sel=11 num=9 (MIN_MAX=59) -> min_tens=5; sel=00 num=12 -> sec_ones=9; load with adj=0 -> no change.
3. Preset 59:58 up, 2 ticks -> 59:59 then 00:00, wrap_p high exactly one cycle, running=1.
4. Preset 00:03 down, start, 5 ticks -> 00:00 after 3rd tick, done=1, running=0, further ticks hold 00:00; pause press clears done.
5. Pause rise coincident with tick while running at 00:10 up -> digits 00:11, running=0 next cycle; reset_c asserted mid-count -> all outputs 0 immediately.
6. LAP_HOLD_EN: at 00:20 lap edge, 5 ticks -> outputs stay 00:20; second lap edge -> outputs 00:25.

Source files
------------

// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD MM:SS stopwatch / countdown timer with pause toggle,
// adjust-mode digit loading, wrap pulse and sticky countdown-done flag.
// Optional lap hold display freeze is built when LAP_HOLD_EN is defined.
module stopwatch_core #(
   parameter int unsigned MIN_MAX        = 59,
   parameter bit          DIR_UP_DEFAULT = 1'b1
) (
   input  logic       clk_c,
   input  logic       reset_c,
   input  logic       tick_1hz,
   input  logic       pause_c,
   input  logic       adj,
   input  logic       load_c,
   input  logic [1:0] sel,
   input  logic [3:0] num,
   input  logic       dir_up,
   input  logic       clr_c,
   input  logic       lap_c,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       wrap_p,
   output logic       done
);

   localparam logic [3:0] MT_MAX = 4'(MIN_MAX / 10);
   localparam logic [3:0] MO_TOP = 4'(MIN_MAX % 10);

   logic [3:0] s1, s10, m1, m10;
   logic [3:0] s1_n, s10_n, m1_n, m10_n;
   logic       run_q, run_n;
   logic       wrap_q, wrap_n;
   logic       done_q, done_n;
   logic       dir_q, dir_n;
   logic       pause_q;
   logic       rise;
   logic [3:0] mo_lim;

   // Next-state for live digits, run flag, wrap pulse, done flag and direction
   always_comb begin
      s1_n   = s1;
      s10_n  = s10;
      m1_n   = m1;
      m10_n  = m10;
      run_n  = run_q;
      wrap_n = 1'b0;
      done_n = done_q;
      dir_n  = dir_q;
      rise   = pause_c & ~pause_q;
      mo_lim = (m10 == MT_MAX) ? MO_TOP : 4'd9;

      if (tick_1hz)
         dir_n = dir_up;

      if (clr_c) begin
         s1_n   = 4'd0;
         s10_n  = 4'd0;
         m1_n   = 4'd0;
         m10_n  = 4'd0;
         done_n = 1'b0;
         if (adj)
            run_n = 1'b0;
         else if (rise)
            run_n = ~run_q;
      end else if (adj) begin
         run_n = 1'b0;
         if (load_c) begin
            done_n = 1'b0;
            case (sel)
               2'd0: s1_n  = (num > 4'd9) ? 4'd9 : num;
               2'd1: s10_n = (num > 4'd5) ? 4'd5 : num;
               2'd2: m1_n  = (num > mo_lim) ? mo_lim : num;
               default: begin
                  m10_n = (num > MT_MAX) ? MT_MAX : num;
                  // Reaching the top minute-tens value may make min ones illegal
                  if (m10_n == MT_MAX && m1 > MO_TOP)
                     m1_n = MO_TOP;
               end
            endcase
         end
      end else begin
         if (rise) begin
            run_n = ~run_q;
            if (!run_q)
               done_n = 1'b0;
         end
         if (tick_1hz && run_q) begin
            if (dir_n) begin
               if (s1 != 4'd9) begin
                  s1_n = s1 + 4'd1;
               end else begin
                  s1_n = 4'd0;
                  if (s10 != 4'd5) begin
                     s10_n = s10 + 4'd1;
                  end else begin
                     s10_n = 4'd0;
                     if (m10 == MT_MAX && m1 == MO_TOP) begin
                        m1_n   = 4'd0;
                        m10_n  = 4'd0;
                        wrap_n = 1'b1;
                     end else if (m1 == 4'd9) begin
                        m1_n  = 4'd0;
                        m10_n = m10 + 4'd1;
                     end else begin
                        m1_n = m1 + 4'd1;
                     end
                  end
               end
            end else if ({m10, m1, s10, s1} == 16'd0) begin
               run_n  = 1'b0;
               done_n = 1'b1;
            end else begin
               if (s1 != 4'd0) begin
                  s1_n = s1 - 4'd1;
               end else begin
                  s1_n = 4'd9;
                  if (s10 != 4'd0) begin
                     s10_n = s10 - 4'd1;
                  end else begin
                     s10_n = 4'd5;
                     if (m1 != 4'd0) begin
                        m1_n = m1 - 4'd1;
                     end else begin
                        m1_n  = 4'd9;
                        m10_n = m10 - 4'd1;
                     end
                  end
               end
               // Last borrow lands on 00:00
               if ({m10, m1, s10} == 12'd0 && s1 == 4'd1) begin
                  run_n  = 1'b0;
                  done_n = 1'b1;
               end
            end
         end
      end
   end

   // Core state registers
   always_ff @(posedge clk_c or posedge reset_c) begin
      if (reset_c) begin
         s1      <= 4'd0;
         s10     <= 4'd0;
         m1      <= 4'd0;
         m10     <= 4'd0;
         run_q   <= 1'b0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
         dir_q   <= DIR_UP_DEFAULT;
         pause_q <= 1'b0;
      end else begin
         s1      <= s1_n;
         s10     <= s10_n;
         m1      <= m1_n;
         m10     <= m10_n;
         run_q   <= run_n;
         wrap_q  <= wrap_n;
         done_q  <= done_n;
         dir_q   <= dir_n;
         pause_q <= pause_c;
      end
   end

   assign running = run_q;
   assign wrap_p  = wrap_q;
   assign done    = done_q;

`ifdef LAP_HOLD_EN
   logic       lap_q, hold_q, hold_n;
   logic [3:0] d_s1, d_s10, d_m1, d_m10;

   // Lap toggle while running; dropped on clear, adjust or running falling
   always_comb begin
      hold_n = hold_q;
      if (lap_c && !lap_q && run_q)
         hold_n = ~hold_q;
      if (clr_c || adj || (run_q && !run_n))
         hold_n = 1'b0;
   end

   // Display registers follow live digits unless a lap is held
   always_ff @(posedge clk_c or posedge reset_c) begin
      if (reset_c) begin
         lap_q  <= 1'b0;
         hold_q <= 1'b0;
         d_s1   <= 4'd0;
         d_s10  <= 4'd0;
         d_m1   <= 4'd0;
         d_m10  <= 4'd0;
      end else begin
         lap_q  <= lap_c;
         hold_q <= hold_n;
         if (!hold_n) begin
            d_s1  <= s1_n;
            d_s10 <= s10_n;
            d_m1  <= m1_n;
            d_m10 <= m10_n;
         end
      end
   end

   assign sec_ones = d_s1;
   assign sec_tens = d_s10;
   assign min_ones = d_m1;
   assign min_tens = d_m10;
`else
   wire unused_lap = lap_c;

   assign sec_ones = s1;
   assign sec_tens = s10;
   assign min_ones = m1;
   assign min_tens = m10;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed steps then random traffic, every cycle
// compared with a seconds-based reference model.
module tb_stopwatch_core;

   localparam int unsigned MIN_MAX = 59;
   localparam int MAXT = (MIN_MAX + 1) * 60 - 1;

   logic       clk_c = 1'b0;
   logic       reset_c, tick_1hz, pause_c, adj, load_c, dir_up, clr_c, lap_c;
   logic [1:0] sel;
   logic [3:0] num;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       running, wrap_p, done;

   int n_chk = 0;
   int n_err = 0;

   // reference model state: total seconds, displayed seconds, flags
   int m_tot, m_disp;
   bit m_run, m_done, m_wrap, m_pq, m_lq, m_hold;

   stopwatch_core #(.MIN_MAX(MIN_MAX), .DIR_UP_DEFAULT(1'b1)) dut (
      .clk_c(clk_c), .reset_c(reset_c), .tick_1hz(tick_1hz), .pause_c(pause_c),
      .adj(adj), .load_c(load_c), .sel(sel), .num(num), .dir_up(dir_up),
      .clr_c(clr_c), .lap_c(lap_c), .sec_ones(sec_ones), .sec_tens(sec_tens),
      .min_ones(min_ones), .min_tens(min_tens), .running(running),
      .wrap_p(wrap_p), .done(done)
   );

   always #5 clk_c = ~clk_c;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_tot = 0; m_disp = 0; m_run = 0; m_done = 0;
      m_wrap = 0; m_pq = 0; m_lq = 0; m_hold = 0;
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // One clock of the reference model using the currently driven inputs
   task automatic model_step();
      bit rise, was_run;
      int so, st, mo, mt, n;
      rise    = pause_c && !m_pq;
      was_run = m_run;
      m_wrap  = 0;
      n       = int'(num);
      if (clr_c) begin
         m_tot = 0; m_done = 0;
         if (adj) m_run = 0;
         else if (rise) m_run = !m_run;
      end else if (adj) begin
         m_run = 0;
         if (load_c) begin
            m_done = 0;
            so = (m_tot % 60) % 10;  st = (m_tot % 60) / 10;
            mo = (m_tot / 60) % 10;  mt = (m_tot / 60) / 10;
            case (sel)
               2'd0: so = imin(n, 9);
               2'd1: st = imin(n, 5);
               2'd2: mo = imin(n, (mt == MIN_MAX / 10) ? MIN_MAX % 10 : 9);
               default: begin
                  mt = imin(n, MIN_MAX / 10);
                  if (mt == MIN_MAX / 10) mo = imin(mo, MIN_MAX % 10);
               end
            endcase
            m_tot = (mt * 10 + mo) * 60 + st * 10 + so;
         end
      end else begin
         if (rise) begin
            m_run = !was_run;
            if (!was_run) m_done = 0;
         end
         if (tick_1hz && was_run) begin
            if (dir_up) begin
               if (m_tot == MAXT) begin m_tot = 0; m_wrap = 1; end
               else m_tot++;
            end else begin
               if (m_tot > 0) m_tot--;
               if (m_tot == 0) begin m_done = 1; m_run = 0; end
            end
         end
      end
`ifdef LAP_HOLD_EN
      if (lap_c && !m_lq && was_run) m_hold = !m_hold;
      if (clr_c || adj || (was_run && !m_run)) m_hold = 0;
      if (!m_hold) m_disp = m_tot;
`else
      m_disp = m_tot;
`endif
      m_lq = lap_c;
      m_pq = pause_c;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".sec_ones"}, 32'(sec_ones), 32'((m_disp % 60) % 10));
      chk({tag, ".sec_tens"}, 32'(sec_tens), 32'((m_disp % 60) / 10));
      chk({tag, ".min_ones"}, 32'(min_ones), 32'((m_disp / 60) % 10));
      chk({tag, ".min_tens"}, 32'(min_tens), 32'((m_disp / 60) / 10));
      chk({tag, ".running"},  32'(running),  32'(m_run));
      chk({tag, ".wrap_p"},   32'(wrap_p),   32'(m_wrap));
      chk({tag, ".done"},     32'(done),     32'(m_done));
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clk_c);
      #1;
      check_all(tag);
   endtask

   task automatic press(input string tag);
      pause_c = 1'b1; step(tag);
      pause_c = 1'b0; step(tag);
   endtask

   task automatic do_tick(input string tag);
      tick_1hz = 1'b1; step(tag);
      tick_1hz = 1'b0; step(tag);
   endtask

   task automatic do_load(input string tag, input int s, input int n);
      sel = 2'(s); num = 4'(n); load_c = 1'b1; step(tag);
      load_c = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".sec_ones"}, 32'(sec_ones), 32'd0);
      chk({tag, ".sec_tens"}, 32'(sec_tens), 32'd0);
      chk({tag, ".min_ones"}, 32'(min_ones), 32'd0);
      chk({tag, ".min_tens"}, 32'(min_tens), 32'd0);
      chk({tag, ".running"},  32'(running),  32'd0);
      chk({tag, ".wrap_p"},   32'(wrap_p),   32'd0);
      chk({tag, ".done"},     32'(done),     32'd0);
   endtask

   initial begin
      reset_c = 1'b1; tick_1hz = 1'b0; pause_c = 1'b0; adj = 1'b0; load_c = 1'b0;
      dir_up = 1'b1; clr_c = 1'b0; lap_c = 1'b0; sel = 2'd0; num = 4'd0;
      model_reset();
      #12;
      chk_zero("reset");
      @(posedge clk_c); #1;
      reset_c = 1'b0;

      // count up 65 s from 00:00
      press("t1_start");
      for (int i = 0; i < 65; i++) do_tick("t1_up");
      chk("t1_sec_ones", 32'(sec_ones), 32'd5);
      chk("t1_min_ones", 32'(min_ones), 32'd1);
      chk("t1_running",  32'(running),  32'd1);

      // adjust loads with clamping, load outside adjust ignored, clear beats load
      adj = 1'b1; step("t2_adj");
      do_load("t2_mt", 3, 9);
      chk("t2_min_tens_clamp", 32'(min_tens), 32'd5);
      do_load("t2_so", 0, 12);
      chk("t2_sec_ones_clamp", 32'(sec_ones), 32'd9);
      do_load("t2_st", 1, 7);
      chk("t2_sec_tens_clamp", 32'(sec_tens), 32'd5);
      adj = 1'b0;
      do_load("t2_noadj", 0, 3);
      chk("t2_load_ignored", 32'(sec_ones), 32'd9);
      adj = 1'b1; clr_c = 1'b1;
      do_load("t2_clr_load", 0, 4);
      clr_c = 1'b0;
      chk("t2_clr_priority", 32'(sec_ones), 32'd0);

      // wrap 59:59 -> 00:00
      do_load("t3", 3, 5); do_load("t3", 2, 9); do_load("t3", 1, 5); do_load("t3", 0, 8);
      adj = 1'b0; step("t3_exit");
      press("t3_start");
      do_tick("t3_tick1");
      tick_1hz = 1'b1; step("t3_tick2");
      chk("t3_wrap_high", 32'(wrap_p), 32'd1);
      chk("t3_wrapped_min_tens", 32'(min_tens), 32'd0);
      tick_1hz = 1'b0; step("t3_after");
      chk("t3_wrap_low", 32'(wrap_p), 32'd0);
      chk("t3_running", 32'(running), 32'd1);

      // countdown from 00:03
      press("t4_stop");
      adj = 1'b1;
      do_load("t4", 3, 0); do_load("t4", 2, 0); do_load("t4", 1, 0); do_load("t4", 0, 3);
      adj = 1'b0; dir_up = 1'b0; step("t4_exit");
      press("t4_start");
      for (int i = 0; i < 3; i++) do_tick("t4_down");
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_stopped", 32'(running), 32'd0);
      do_tick("t4_extra"); do_tick("t4_extra");
      chk("t4_hold_zero", 32'(sec_ones), 32'd0);
      press("t4_restart");
      chk("t4_done_cleared", 32'(done), 32'd0);
      do_tick("t4_zero_tick");
      chk("t4_zero_tick_done", 32'(done), 32'd1);

      // pause edge coincident with tick, then async reset mid-count
      adj = 1'b1; dir_up = 1'b1;
      do_load("t5", 1, 1); do_load("t5", 0, 0);
      adj = 1'b0; step("t5_exit");
      press("t5_start");
      pause_c = 1'b1; tick_1hz = 1'b1; step("t5_coinc");
      chk("t5_counted", 32'(sec_ones), 32'd1);
      chk("t5_paused", 32'(running), 32'd0);
      pause_c = 1'b0; tick_1hz = 1'b0; step("t5_idle");
      press("t5_run");
      do_tick("t5_more"); do_tick("t5_more");
      #2 reset_c = 1'b1;
      #1 model_reset();
      chk_zero("t5_async_reset");
      @(posedge clk_c); #1;
      reset_c = 1'b0;

      // lap hold at 00:20
      adj = 1'b1; step("t6_adj");
      do_load("t6", 1, 2);
      adj = 1'b0; step("t6_exit");
      press("t6_start");
      lap_c = 1'b1; step("t6_lap"); lap_c = 1'b0; step("t6_lap");
      for (int i = 0; i < 5; i++) do_tick("t6_tick");
`ifdef LAP_HOLD_EN
      chk("t6_frozen", 32'(sec_ones), 32'd0);
`else
      chk("t6_live", 32'(sec_ones), 32'd5);
`endif
      lap_c = 1'b1; step("t6_release"); lap_c = 1'b0; step("t6_release");
      chk("t6_sec_ones", 32'(sec_ones), 32'd5);
      chk("t6_sec_tens", 32'(sec_tens), 32'd2);

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         tick_1hz = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 49) == 0) dir_up = ~dir_up;
         if ($urandom_range(0, 29) == 0) lap_c = ~lap_c;
         if ($urandom_range(0, 299) == 0) adj = ~adj;
         load_c = adj && ($urandom_range(0, 2) == 0);
         sel = 2'($urandom_range(0, 3));
         num = 4'($urandom_range(0, 15));
         clr_c = 1'b0;
         if ($urandom_range(0, 39) == 0) pause_c = ~pause_c;
         else clr_c = ($urandom_range(0, 199) == 0);
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
